dm_bank_arb: RTL and testbench
==============================

Name: dm_bank_arb

Overview:
- Per-PE data-memory bank directly downstream of the PE load/store unit; consumes its active-low read/write strobes, word address, write data and bit-enable mask, and returns read data one cycle later.
- A second host/DMA port (valid/ready) preloads and drains the bank between kernel iterations.
- PE port has strict priority. Host is served only in cycles where the PE port is idle.

Parameters:
- DATA_WIDTH, 32, word width in bits; multiple of 8.
- DEPTH, 512, number of words.
- ADDR_W, $clog2(DEPTH) = 9, word address width.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high
- pe_rd_en_n  input  1  PE read strobe, active low
- pe_wr_en_n  input  1  PE write strobe, active low
- pe_addr  input  ADDR_W  PE word address
- pe_wdata  input  DATA_WIDTH  PE write data
- pe_bit_en  input  DATA_WIDTH  per-bit write mask, 1 = write
- pe_rdata  output  DATA_WIDTH  registered PE read data
- host_req_valid  input  1  host request valid
- host_req_ready  output  1  host request accepted this cycle
- host_req_we  input  1  1 = write, 0 = read
- host_req_addr  input  ADDR_W  host word address
- host_req_wdata  input  DATA_WIDTH  host write data, full-word write
- host_rsp_valid  output  1  host read response valid
- host_rsp_data  output  DATA_WIDTH  host read data
- host_rsp_ready  input  1  host accepts response
- starve_cnt  output  16  host-blocked cycle counter
- err_sticky  output  1  illegal PE strobe combination seen
- parity_err  output  1  sticky parity error

Behaviour:
- Reset: pe_rdata=0, host_req_ready=0, host_rsp_valid=0, host_rsp_data=0, starve_cnt=0, err_sticky=0, parity_err=0. Memory contents are not cleared.
- PE busy is defined as pe_rd_en_n==0 or pe_wr_en_n==0.
- PE write (wr_n=0, rd_n=1): mem[a] <= (mem[a] & ~pe_bit_en) | (pe_wdata & pe_bit_en) at the edge.
- PE read (rd_n=0, wr_n=1): pe_rdata <= mem[pe_addr] at the edge, so it is valid the cycle after the strobe. pe_rdata holds its value until the next PE read.
- Both PE strobes low: the write executes, pe_rdata holds, and err_sticky is set. err_sticky clears only on reset.
- Host FSM has two states:
  - IDLE: host_req_ready = host_req_valid & ~PE busy & ~host_rsp_valid (combinational).
    - On an accepted write, mem is written with the full word next edge; the FSM stays in IDLE.
    - On an accepted read, host_rsp_data <= mem[host_req_addr], host_rsp_valid <= 1, and the FSM goes to RSP.
  - RSP: host_rsp_valid=1 and host_rsp_data are held stable. host_req_ready=0. On host_rsp_ready, host_rsp_valid <= 0 and the FSM returns to IDLE. A new request is accepted at the earliest one cycle later.
- Same-cycle PE and host request: PE wins and host_req_ready=0. The host request must remain asserted and stable until accepted.
- starve_cnt increments each cycle with host_req_valid & PE busy. It saturates at 16'hFFFF and clears on reset only.
- Reset asserted while in RSP returns the FSM to IDLE and drops the response.
- Out-of-range addresses (>= DEPTH, when DEPTH is not a power of 2): writes are ignored and reads return 0.

Optional Feature:
- Macro DM_PARITY_EN.
- With it defined:
  - Each word stores DATA_WIDTH/8 even-parity bits, one per byte.
  - On any write, parity is regenerated for every byte lane whose pe_bit_en byte is all 1s (full word for host writes).
  - A partially set byte lane in pe_bit_en (neither all 0s nor all 1s) sets err_sticky; the data write still executes and that lane's parity is marked bad.
  - Every PE or host read checks parity; a mismatch sets parity_err (sticky, cleared on reset).
- Without it: no parity storage, and parity_err is tied 0.

Test Plan:
- PE write addr 9'h010 data 32'hDEADBEEF mask all 1s, then PE read 9'h010 -> pe_rdata=32'hDEADBEEF exactly one cycle after the read strobe.
- Preload 32'h11223344, then PE write 32'hAABBCCDD with mask 32'h0000FF00, then read -> 32'h1122CC44.
- Host read valid while PE strobes low for 3 cycles -> host_req_ready=0 for 3 cycles, starve_cnt=3, accepted on cycle 4, rsp valid next cycle.
- Host read with host_rsp_ready held 0 for 5 cycles -> rsp_valid/data stable for 5 cycles, no new request accepted; ready=1 -> valid drops next edge.
- Both PE strobes low with wdata 32'h5 at 9'h020 -> mem[9'h020]=5, pe_rdata unchanged, err_sticky=1.
- DM_PARITY_EN: force a flipped data bit via backdoor at 9'h030, then host read -> parity_err=1. Without the macro -> parity_err stays 0.

Source files
------------

// File: rtl/dm_bank_arb.sv
// Per-PE data-memory bank: strict-priority PE load/store port plus a valid/ready host port.
// Define DM_PARITY_EN to add per-byte even parity storage and read checking.
module dm_bank_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 512,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pe_rd_en_n,
    input  logic                  pe_wr_en_n,
    input  logic [ADDR_W-1:0]     pe_addr,
    input  logic [DATA_WIDTH-1:0] pe_wdata,
    input  logic [DATA_WIDTH-1:0] pe_bit_en,
    output logic [DATA_WIDTH-1:0] pe_rdata,
    input  logic                  host_req_valid,
    output logic                  host_req_ready,
    input  logic                  host_req_we,
    input  logic [ADDR_W-1:0]     host_req_addr,
    input  logic [DATA_WIDTH-1:0] host_req_wdata,
    output logic                  host_rsp_valid,
    output logic [DATA_WIDTH-1:0] host_rsp_data,
    input  logic                  host_rsp_ready,
    output logic [15:0]           starve_cnt,
    output logic                  err_sticky,
    output logic                  parity_err
);

    typedef enum logic {S_IDLE, S_RSP} state_t;
    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  pe_busy, pe_wr, pe_rd, pe_both;
    logic                  host_wr, host_rd;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr, rd_addr;
    logic [DATA_WIDTH-1:0] wr_data, wr_mask, old_word, merged, rd_word;
    logic                  lane_err;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (ADDR_W+1)'(a) < (ADDR_W+1)'(DEPTH);
    endfunction

    assign pe_busy = ~pe_rd_en_n | ~pe_wr_en_n;
    assign pe_wr   = ~pe_wr_en_n;
    assign pe_rd   = ~pe_rd_en_n & pe_wr_en_n;
    assign pe_both = ~pe_rd_en_n & ~pe_wr_en_n;
    assign host_wr = host_req_ready & host_req_we;
    assign host_rd = host_req_ready & ~host_req_we;

    // Host is only ever accepted while the PE is idle, so one shared write port suffices.
    assign wr_en    = (pe_wr | host_wr) & in_range(wr_addr);
    assign wr_addr  = pe_wr ? pe_addr   : host_req_addr;
    assign wr_data  = pe_wr ? pe_wdata  : host_req_wdata;
    assign wr_mask  = pe_wr ? pe_bit_en : '1;
    assign old_word = in_range(wr_addr) ? mem[wr_addr] : '0;
    assign merged   = (old_word & ~wr_mask) | (wr_data & wr_mask);
    assign rd_addr  = pe_rd ? pe_addr : host_req_addr;
    assign rd_word  = in_range(rd_addr) ? mem[rd_addr] : '0;

    // NOTE: every variable written here gets a default first, so no latches are inferred.
    always_comb begin
        state_nxt      = state;
        host_req_ready = 1'b0;
        case (state)
            S_IDLE: begin
                host_req_ready = host_req_valid & ~pe_busy & ~host_rsp_valid & ~reset;
                if (host_req_ready && !host_req_we) state_nxt = S_RSP;
            end
            S_RSP: if (host_rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            pe_rdata       <= '0;
            host_rsp_valid <= 1'b0;
            host_rsp_data  <= '0;
            starve_cnt     <= '0;
            err_sticky     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (pe_rd) pe_rdata <= rd_word;
            if (host_rd) begin
                host_rsp_valid <= 1'b1;
                host_rsp_data  <= rd_word;
            end else if (state == S_RSP && host_rsp_ready) begin
                host_rsp_valid <= 1'b0;
            end
            if (host_req_valid && pe_busy && starve_cnt != 16'hFFFF)
                starve_cnt <= starve_cnt + 16'd1;
            if (pe_both || lane_err) err_sticky <= 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= merged;
    end

`ifdef DM_PARITY_EN
    localparam int NB = DATA_WIDTH / 8;

    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] par_old, par_wr, lane_part, rd_par_calc, rd_par_stored;
    logic          rd_par_bad;

    assign par_old       = in_range(wr_addr) ? par_mem[wr_addr] : '0;
    assign rd_par_stored = in_range(rd_addr) ? par_mem[rd_addr] : '0;

    // A partially-written lane gets inverted parity so any later read of it flags an error.
    always_comb begin
        par_wr      = par_old;
        lane_part   = '0;
        rd_par_calc = '0;
        for (int i = 0; i < NB; i++) begin
            if (&wr_mask[8*i +: 8]) begin
                par_wr[i] = ^merged[8*i +: 8];
            end else if (|wr_mask[8*i +: 8]) begin
                par_wr[i]    = ~^merged[8*i +: 8];
                lane_part[i] = 1'b1;
            end
            rd_par_calc[i] = ^rd_word[8*i +: 8];
        end
    end

    assign lane_err   = pe_wr & |lane_part;
    assign rd_par_bad = (pe_rd | host_rd) & in_range(rd_addr) & (rd_par_calc != rd_par_stored);

    always_ff @(posedge clk) begin
        if (wr_en) par_mem[wr_addr] <= par_wr;
    end

    always_ff @(posedge clk) begin
        if (reset)           parity_err <= 1'b0;
        else if (rd_par_bad) parity_err <= 1'b1;
    end
`else
    assign lane_err   = 1'b0;
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_dm_bank_arb.sv
// Self-checking bench for dm_bank_arb: directed scenarios then randomized PE/host traffic
// checked against a word-level memory model with per-lane parity-health flags.
module tb_dm_bank_arb;

`ifdef DM_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        pe_rd_en_n, pe_wr_en_n;
    logic [8:0]  pe_addr;
    logic [31:0] pe_wdata, pe_bit_en, pe_rdata;
    logic        host_req_valid, host_req_ready, host_req_we;
    logic [8:0]  host_req_addr;
    logic [31:0] host_req_wdata, host_rsp_data;
    logic        host_rsp_valid, host_rsp_ready;
    logic [15:0] starve_cnt;
    logic        err_sticky, parity_err;

    dm_bank_arb dut (
        .clk(clk), .reset(reset),
        .pe_rd_en_n(pe_rd_en_n), .pe_wr_en_n(pe_wr_en_n), .pe_addr(pe_addr),
        .pe_wdata(pe_wdata), .pe_bit_en(pe_bit_en), .pe_rdata(pe_rdata),
        .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
        .host_req_we(host_req_we), .host_req_addr(host_req_addr),
        .host_req_wdata(host_req_wdata), .host_rsp_valid(host_rsp_valid),
        .host_rsp_data(host_rsp_data), .host_rsp_ready(host_rsp_ready),
        .starve_cnt(starve_cnt), .err_sticky(err_sticky), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    // Reference model: word contents and which byte lanes hold untrustworthy parity.
    logic [31:0] mdl  [64];
    logic [3:0]  mbad [64];
    logic [31:0] exp_pe_rdata;
    logic [15:0] exp_starve;
    logic        exp_err, exp_par;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        if (host_req_valid && (!pe_rd_en_n || !pe_wr_en_n) && exp_starve != 16'hFFFF)
            exp_starve++;
        @(posedge clk);
        #1;
    endtask

    task automatic pe_op(input bit rd, input bit wr, input logic [8:0] a,
                         input logic [31:0] d, input logic [31:0] m);
        pe_rd_en_n = !rd; pe_wr_en_n = !wr; pe_addr = a; pe_wdata = d; pe_bit_en = m;
        tick();
        if (rd && !wr) begin
            exp_pe_rdata = mdl[a[5:0]];
            if (PAR && mbad[a[5:0]] != 4'h0) exp_par = 1'b1;
        end
        if (wr) begin
            mdl[a[5:0]] = (mdl[a[5:0]] & ~m) | (d & m);
            for (int i = 0; i < 4; i++) begin
                logic [7:0] lane;
                lane = m[8*i +: 8];
                if (lane == 8'hFF) mbad[a[5:0]][i] = 1'b0;
                else if (lane != 8'h00 && PAR) begin
                    mbad[a[5:0]][i] = 1'b1;
                    exp_err = 1'b1;
                end
            end
        end
        if (rd && wr) exp_err = 1'b1;
        pe_rd_en_n = 1'b1; pe_wr_en_n = 1'b1;
        if (rd) check("pe_rdata", pe_rdata, exp_pe_rdata);
    endtask

    task automatic host_op(input bit we, input logic [8:0] a, input logic [31:0] d, input int hold);
        int n;
        logic [31:0] held;
        n = 0;
        host_req_valid = 1'b1; host_req_we = we; host_req_addr = a; host_req_wdata = d;
        #1;
        while (!host_req_ready && n < 20) begin tick(); n++; end
        check("host_accept_timeout", 32'(n < 20), 32'd1);
        tick();
        host_req_valid = 1'b0;
        if (we) begin
            mdl[a[5:0]]  = d;
            mbad[a[5:0]] = 4'h0;
        end else begin
            if (PAR && mbad[a[5:0]] != 4'h0) exp_par = 1'b1;
            check("rsp_valid", 32'(host_rsp_valid), 32'd1);
            check("rsp_data", host_rsp_data, mdl[a[5:0]]);
            held = mdl[a[5:0]];
            for (int i = 0; i < hold; i++) begin
                tick();
                check("rsp_hold_valid", 32'(host_rsp_valid), 32'd1);
                check("rsp_hold_data", host_rsp_data, held);
            end
            host_rsp_ready = 1'b1;
            tick();
            host_rsp_ready = 1'b0;
            check("rsp_drop", 32'(host_rsp_valid), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] held_data;
        logic [31:0] rmask;
        reset = 1'b1;
        pe_rd_en_n = 1'b1; pe_wr_en_n = 1'b1; pe_addr = '0; pe_wdata = '0; pe_bit_en = '0;
        host_req_valid = 1'b1; host_req_we = 1'b0; host_req_addr = '0; host_req_wdata = '0;
        host_rsp_ready = 1'b0;
        exp_pe_rdata = '0; exp_starve = '0; exp_err = 1'b0; exp_par = 1'b0;
        for (int i = 0; i < 64; i++) begin mdl[i] = '0; mbad[i] = '0; end

        // Reset values, with a host request pending to prove ready is held low.
        tick(); tick();
        check("rst_ready", 32'(host_req_ready), 32'd0);
        check("rst_pe_rdata", pe_rdata, 32'd0);
        check("rst_rsp_valid", 32'(host_rsp_valid), 32'd0);
        check("rst_rsp_data", host_rsp_data, 32'd0);
        check("rst_starve", 32'(starve_cnt), 32'd0);
        check("rst_err", 32'(err_sticky), 32'd0);
        check("rst_parity", 32'(parity_err), 32'd0);
        host_req_valid = 1'b0;
        reset = 1'b0;
        tick();

        // Preload the modelled window through the host port.
        for (int i = 0; i < 64; i++) host_op(1'b1, 9'(i), $urandom, 0);

        // Full-word write, then read one cycle later.
        pe_op(0, 1, 9'h010, 32'hDEADBEEF, 32'hFFFFFFFF);
        pe_op(1, 0, 9'h010, '0, '0);
        check("read_deadbeef", pe_rdata, 32'hDEADBEEF);

        // Masked write merges a single byte lane.
        host_op(1'b1, 9'h011, 32'h11223344, 0);
        pe_op(0, 1, 9'h011, 32'hAABBCCDD, 32'h0000FF00);
        pe_op(1, 0, 9'h011, '0, '0);
        check("mask_merge", pe_rdata, 32'h1122CC44);

        // Host starved by 3 cycles of PE reads, accepted on the 4th.
        host_req_valid = 1'b1; host_req_we = 1'b0; host_req_addr = 9'h012;
        pe_rd_en_n = 1'b0; pe_addr = 9'h010;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ready_blocked", 32'(host_req_ready), 32'd0);
            tick();
        end
        exp_pe_rdata = mdl[6'h10];
        pe_rd_en_n = 1'b1;
        #1;
        check("starve_three", 32'(starve_cnt), 32'd3);
        check("starve_model", 32'(starve_cnt), 32'(exp_starve));
        check("ready_free", 32'(host_req_ready), 32'd1);
        tick();
        host_req_valid = 1'b0;
        check("starve_rsp_valid", 32'(host_rsp_valid), 32'd1);
        check("starve_rsp_data", host_rsp_data, mdl[6'h12]);

        // Response back-pressured for 5 cycles while a new request waits.
        held_data = mdl[6'h12];
        host_req_valid = 1'b1; host_req_we = 1'b1; host_req_addr = 9'h013; host_req_wdata = 32'hCAFEF00D;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("rsp_block_ready", 32'(host_req_ready), 32'd0);
            tick();
            check("bp_valid", 32'(host_rsp_valid), 32'd1);
            check("bp_data", host_rsp_data, held_data);
        end
        host_rsp_ready = 1'b1;
        #1;
        check("rsp_edge_ready", 32'(host_req_ready), 32'd0);
        tick();
        host_rsp_ready = 1'b0;
        check("bp_drop", 32'(host_rsp_valid), 32'd0);
        check("next_req_ready", 32'(host_req_ready), 32'd1);
        tick();
        host_req_valid = 1'b0;
        mdl[6'h13] = 32'hCAFEF00D; mbad[6'h13] = 4'h0;
        pe_op(1, 0, 9'h013, '0, '0);

        // Both strobes low: write happens, read data holds, error latches.
        pe_op(1, 1, 9'h020, 32'h5, 32'hFFFFFFFF);
        check("both_err", 32'(err_sticky), 32'd1);
        pe_op(1, 0, 9'h020, '0, '0);
        check("both_written", pe_rdata, 32'h5);

        // Backdoor bit flip is caught by parity only when parity is built in.
`ifdef DM_PARITY_EN
        dut.mem[9'h030] = dut.mem[9'h030] ^ 32'h1;
        mdl[6'h30] = mdl[6'h30] ^ 32'h1;
        mbad[6'h30][0] = 1'b1;
`endif
        host_op(1'b0, 9'h030, '0, 0);
        check("parity_flag", 32'(parity_err), 32'(PAR));

        // Randomized mixed traffic.
        for (int n = 0; n < 300; n++) begin
            logic [8:0] a;
            a = 9'($urandom_range(0, 63));
            case ($urandom_range(0, 5))
                0: pe_op(0, 1, a, $urandom, 32'hFFFFFFFF);
                1: begin
                    rmask = (PAR && $urandom_range(0, 3) == 0) ? $urandom
                          : {{8{1'($urandom)}}, {8{1'($urandom)}}, {8{1'($urandom)}}, {8{1'($urandom)}}};
                    pe_op(0, 1, a, $urandom, rmask);
                end
                2: pe_op(1, 0, a, '0, '0);
                3: host_op(1'b1, a, $urandom, 0);
                4: host_op(1'b0, a, '0, $urandom_range(0, 3));
                default: tick();
            endcase
        end
        check("final_err", 32'(err_sticky), 32'(exp_err));
        check("final_parity", 32'(parity_err), 32'(exp_par));
        check("final_starve", 32'(starve_cnt), 32'(exp_starve));

        // Reset while in RSP drops the response and frees the port.
        host_req_valid = 1'b1; host_req_we = 1'b0; host_req_addr = 9'h005;
        #1;
        tick();
        host_req_valid = 1'b0;
        check("pre_rst_rsp", 32'(host_rsp_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_pe_rdata = '0; exp_starve = '0; exp_err = 1'b0; exp_par = 1'b0;
        check("rst_rsp_drop", 32'(host_rsp_valid), 32'd0);
        check("rst_err_clr", 32'(err_sticky), 32'd0);
        check("rst_pe_clr", pe_rdata, 32'd0);
        host_req_valid = 1'b1; host_req_we = 1'b0; host_req_addr = 9'h011;
        #1;
        check("post_rst_ready", 32'(host_req_ready), 32'd1);
        host_op(1'b0, 9'h011, '0, 1);
        check("post_rst_parity", 32'(parity_err), 32'(exp_par));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
